// File: rtl/eth_udp_tx_arb.sv
// Packet-level round-robin arbiter sharing one IPv4/UDP framer among CHDR streams.
// Holds the winner's destination tuple for the whole packet and truncates oversized packets.
module eth_udp_tx_arb #(
    parameter int unsigned NUM_PORTS        = 4,
    parameter int unsigned DATA_WIDTH       = 64,
    parameter int unsigned MAX_PACKET_BYTES = 8192
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            port_en,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_PORTS-1:0]            s_tlast,
    input  logic [NUM_PORTS-1:0]            s_tvalid,
    output logic [NUM_PORTS-1:0]            s_tready,
    input  logic [NUM_PORTS*48-1:0]         s_mac_dst,
    input  logic [NUM_PORTS*32-1:0]         s_ip_dst,
    input  logic [NUM_PORTS*16-1:0]         s_udp_dst,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    output logic                            m_tlast,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic [47:0]                     mac_dst,
    output logic [31:0]                     ip_dst,
    output logic [15:0]                     udp_dst,
    output logic [$clog2(NUM_PORTS)-1:0]    grant_port,
    output logic                            busy,
    output logic [15:0]                     trunc_count
);

    localparam int unsigned MAX_BEATS = MAX_PACKET_BYTES / (DATA_WIDTH / 8);
    localparam int unsigned PW        = $clog2(NUM_PORTS);
    localparam int unsigned CW        = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   beat_cnt;

    logic [DATA_WIDTH-1:0] data_arr [NUM_PORTS];
    logic [47:0]           mac_arr  [NUM_PORTS];
    logic [31:0]           ip_arr   [NUM_PORTS];
    logic [15:0]           udp_arr  [NUM_PORTS];

    // Flatten per-port buses into arrays indexed by port number
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign data_arr[g] = s_tdata[g*DATA_WIDTH +: DATA_WIDTH];
        assign mac_arr[g]  = s_mac_dst[g*48 +: 48];
        assign ip_arr[g]   = s_ip_dst[g*32 +: 32];
        assign udp_arr[g]  = s_udp_dst[g*16 +: 16];
    end

    logic [NUM_PORTS-1:0] req;
    logic                 arb_found;
    logic [PW-1:0]        arb_idx;
    logic [PW-1:0]        cand;

    // First requester at or after ptr; scanning from the far end lets the nearest win
    always_comb begin
        req       = s_tvalid & port_en;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            cand = PW'((int'(ptr) + i) % NUM_PORTS);
            if (req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    logic          sel_valid;
    logic          sel_last;
    logic          force_last;
    logic          hs_pass;
    logic          hs_drain;
    logic [PW-1:0] next_ptr;

    assign sel_valid  = s_tvalid[grant_port];
    assign sel_last   = s_tlast[grant_port];
    assign force_last = (beat_cnt == CW'(MAX_BEATS - 1));
    assign hs_pass    = (state == PASS) && sel_valid && m_tready;
    assign hs_drain   = (state == DRAIN) && sel_valid;
    assign next_ptr   = (grant_port == PW'(NUM_PORTS - 1)) ? '0 : grant_port + PW'(1);
    assign busy       = (state != IDLE);

    // Combinational pass-through of the granted stream; DRAIN swallows the tail
    always_comb begin
        m_tdata  = data_arr[grant_port];
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        s_tready = '0;
        case (state)
            PASS: begin
                m_tvalid             = sel_valid;
                m_tlast              = sel_last | force_last;
                s_tready[grant_port] = m_tready;
            end
            DRAIN: begin
                s_tready[grant_port] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_port  <= '0;
            beat_cnt    <= '0;
            mac_dst     <= '0;
            ip_dst      <= '0;
            udp_dst     <= '0;
            trunc_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        grant_port <= arb_idx;
                        mac_dst    <= mac_arr[arb_idx];
                        ip_dst     <= ip_arr[arb_idx];
                        udp_dst    <= udp_arr[arb_idx];
                        beat_cnt   <= '0;
                        state      <= PASS;
                    end
                end
                PASS: begin
                    if (hs_pass) begin
                        beat_cnt <= beat_cnt + CW'(1);
                        if (sel_last) begin
                            ptr   <= next_ptr;
                            state <= IDLE;
                        end else if (force_last) begin
                            if (trunc_count != 16'hFFFF)
                                trunc_count <= trunc_count + 16'd1;
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (hs_drain && sel_last) begin
                        ptr   <= next_ptr;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_udp_tx_arb.sv
// Bench for eth_udp_tx_arb: directed table, hand sequences and random traffic
// checked against a packet-level round-robin reference model.
module tb_eth_udp_tx_arb;

    localparam int NP    = 4;
    localparam int DW    = 64;
    localparam int MAXB  = 8;
    localparam int MAXPK = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NP-1:0]    port_en;
    logic [NP*DW-1:0] s_tdata;
    logic [NP-1:0]    s_tlast;
    logic [NP-1:0]    s_tvalid;
    logic [NP-1:0]    s_tready;
    logic [NP*48-1:0] s_mac_dst;
    logic [NP*32-1:0] s_ip_dst;
    logic [NP*16-1:0] s_udp_dst;
    logic [DW-1:0]    m_tdata;
    logic             m_tlast;
    logic             m_tvalid;
    logic             m_tready;
    logic [47:0]      mac_dst;
    logic [31:0]      ip_dst;
    logic [15:0]      udp_dst;
    logic [1:0]       grant_port;
    logic             busy;
    logic [15:0]      trunc_count;

    always #5 clk = ~clk;

    eth_udp_tx_arb #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_PACKET_BYTES(64)) dut (
        .clk(clk), .rst(rst), .port_en(port_en),
        .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_mac_dst(s_mac_dst), .s_ip_dst(s_ip_dst), .s_udp_dst(s_udp_dst),
        .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .mac_dst(mac_dst), .ip_dst(ip_dst), .udp_dst(udp_dst),
        .grant_port(grant_port), .busy(busy), .trunc_count(trunc_count)
    );

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [NP-1:0] load;
        logic [NP-1:0] en;
        int            npk;
        int            len0;
        int            len1;
        int            exp_beats;
        int            exp_trunc;
        int            exp_span;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    int          pkt_cnt  [NP];
    int          pkt_len  [NP][MAXPK];
    int          cur_pkt  [NP];
    int          cur_beat [NP];
    logic [31:0] salt     [NP];
    logic [47:0] mac_t    [NP];
    logic [31:0] ip_t     [NP];
    logic [15:0] udp_t    [NP];
    int          exp_pkts [NP];
    int          mon_pkts [NP];
    beat_t       expq[$];
    int          exp_trunc;
    int          mon_beats;
    int          cycle;
    int          first_cyc;
    int          last_cyc;
    int          ready_pct = 100;
    int          drop_port = -1;
    logic        drop_now  = 1'b0;

    function automatic logic [DW-1:0] mk_data(input int p, input int k, input int b);
        return {8'(p), 8'(k), 16'(b), salt[p]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            s_tvalid[p] = (cur_pkt[p] < pkt_cnt[p]);
            if (s_tvalid[p]) begin
                s_tdata[p*DW +: DW] = mk_data(p, cur_pkt[p], cur_beat[p]);
                s_tlast[p]          = (cur_beat[p] == pkt_len[p][cur_pkt[p]] - 1);
            end else begin
                s_tdata[p*DW +: DW] = '0;
                s_tlast[p]          = 1'b0;
            end
            s_mac_dst[p*48 +: 48] = mac_t[p];
            s_ip_dst[p*32 +: 32]  = ip_t[p];
            s_udp_dst[p*16 +: 16] = udp_t[p];
        end
        m_tready = ($urandom_range(99) < ready_pct);
    endtask

    // Reference: round-robin over enabled ports with pending packets, truncating to MAXB beats
    task automatic model(input logic [NP-1:0] en);
        int ptr, found, len, n, q;
        int nxt[NP];
        expq.delete();
        exp_trunc = 0;
        ptr = 0;
        for (int p = 0; p < NP; p++) begin
            nxt[p]      = 0;
            exp_pkts[p] = 0;
        end
        while (1) begin
            found = -1;
            for (int i = 0; i < NP; i++) begin
                q = (ptr + i) % NP;
                if (found < 0 && en[q] && nxt[q] < pkt_cnt[q]) found = q;
            end
            if (found < 0) break;
            len = pkt_len[found][nxt[found]];
            n   = (len > MAXB) ? MAXB : len;
            for (int b = 0; b < n; b++)
                expq.push_back('{found, mk_data(found, nxt[found], b), (b == n - 1)});
            if (len > MAXB) exp_trunc++;
            exp_pkts[found]++;
            nxt[found]++;
            ptr = (found + 1) % NP;
        end
    endtask

    task automatic step();
        beat_t e;
        @(negedge clk);
        if (m_tvalid && m_tready) begin
            mon_beats++;
            if (first_cyc < 0) first_cyc = cycle;
            last_cyc = cycle;
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_beat: got data %0h expected none", m_tdata);
            end else begin
                e = expq.pop_front();
                chk("m_tdata", m_tdata, e.data);
                chk("m_tlast", 64'(m_tlast), 64'(e.last));
                chk("grant_port", 64'(grant_port), 64'(e.port));
                chk("mac_dst", 64'(mac_dst), 64'(mac_t[e.port]));
                chk("ip_dst", 64'(ip_dst), 64'(ip_t[e.port]));
                chk("udp_dst", 64'(udp_dst), 64'(udp_t[e.port]));
                chk("busy", 64'(busy), 64'd1);
                if (e.last) mon_pkts[e.port]++;
                if (drop_port == e.port) drop_now = 1'b1;
            end
        end
        chk("s_tready_onehot", 64'($countones(s_tready) <= 1), 64'd1);
        for (int p = 0; p < NP; p++) begin
            if (s_tvalid[p] && s_tready[p]) begin
                if (cur_beat[p] == pkt_len[p][cur_pkt[p]] - 1) begin
                    cur_pkt[p]++;
                    cur_beat[p] = 0;
                end else begin
                    cur_beat[p]++;
                end
            end
        end
        @(posedge clk);
        #1;
        cycle++;
        if (drop_now) begin
            port_en[drop_port] = 1'b0;
            drop_port = -1;
            drop_now  = 1'b0;
        end
        drive();
    endtask

    task automatic run(input int limit);
        int budget;
        budget = 0;
        while (mon_beats < limit && budget < 4000) begin
            step();
            budget++;
        end
        if (mon_beats < limit) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d beats expected %0d", mon_beats, limit);
        end
    endtask

    task automatic hold_reset();
        rst     = 1'b1;
        port_en = '0;
        for (int p = 0; p < NP; p++) begin
            pkt_cnt[p]  = 0;
            cur_pkt[p]  = 0;
            cur_beat[p] = 0;
            mon_pkts[p] = 0;
            salt[p]     = $urandom;
            mac_t[p]    = {32'h02005E00, 16'(p)};
            ip_t[p]     = 32'h0A000000 + 32'(p);
            udp_t[p]    = 16'(4998 + p);
        end
        expq.delete();
        mon_beats = 0;
        first_cyc = -1;
        last_cyc  = -1;
        drive();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_test(input logic [NP-1:0] en);
        port_en = en;
        model(en);
        drive();
        @(posedge clk);
        #1;
        rst   = 1'b0;
        cycle = 0;
    endtask

    task automatic finish_checks(input string tag);
        repeat (6) step();
        chk({tag, "_trunc_count"}, 64'(trunc_count), 64'(exp_trunc));
        for (int p = 0; p < NP; p++)
            chk({tag, "_pkts_port"}, 64'(mon_pkts[p]), 64'(exp_pkts[p]));
    endtask

    vec_t vt[5];

    initial begin
        int n;
        logic [NP-1:0] en;

        vt[0] = '{4'b0100, 4'b0100, 3, 4, 4, 12, 0, 14};
        vt[1] = '{4'b1111, 4'b1111, 10, 2, 2, 80, 0, 119};
        vt[2] = '{4'b1111, 4'b1010, 5, 2, 2, 20, 0, 29};
        vt[3] = '{4'b0001, 4'b0001, 2, 12, 8, 16, 1, 21};
        vt[4] = '{4'b1000, 4'b1000, 2, 8, 1, 9, 0, 10};

        m_tready = 1'b0;
        hold_reset();
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant_port", 64'(grant_port), 64'd0);
        chk("rst_mac_dst", 64'(mac_dst), 64'd0);
        chk("rst_ip_dst", 64'(ip_dst), 64'd0);
        chk("rst_udp_dst", 64'(udp_dst), 64'd0);
        chk("rst_trunc_count", 64'(trunc_count), 64'd0);

        // Directed table: single requester, fairness, enable mask, truncation, exact-limit packet
        for (int t = 0; t < 5; t++) begin
            hold_reset();
            for (int p = 0; p < NP; p++) begin
                if (vt[t].load[p]) begin
                    pkt_cnt[p] = vt[t].npk;
                    for (int k = 0; k < vt[t].npk; k++)
                        pkt_len[p][k] = (k % 2 == 0) ? vt[t].len0 : vt[t].len1;
                end
            end
            ready_pct = 100;
            begin_test(vt[t].en);
            n = expq.size();
            run(n);
            finish_checks("vec");
            chk("vec_beats", 64'(mon_beats), 64'(vt[t].exp_beats));
            chk("vec_trunc", 64'(trunc_count), 64'(vt[t].exp_trunc));
            chk("vec_span", 64'(last_cyc - first_cyc + 1), 64'(vt[t].exp_span));
        end

        // Clearing port_en of the granted port mid-packet still completes that packet
        hold_reset();
        pkt_cnt[1] = 1; pkt_len[1][0] = 4;
        pkt_cnt[3] = 1; pkt_len[3][0] = 2;
        ready_pct = 100;
        drop_port = 1;
        begin_test(4'b1010);
        n = expq.size();
        run(n);
        finish_checks("drop_en");
        chk("drop_en_cleared", 64'(port_en[1]), 64'd0);

        // Reset on beat 3 of a 6-beat packet from port 1, then port 0 must win first
        hold_reset();
        pkt_cnt[0] = 1; pkt_len[0][0] = 2;
        pkt_cnt[1] = 1; pkt_len[1][0] = 6;
        ready_pct = 100;
        begin_test(4'b1111);
        run(5);
        chk("pre_rst_m_tvalid", 64'(m_tvalid), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("mid_rst_s_tready", 64'(s_tready), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("mid_rst_grant_port", 64'(grant_port), 64'd0);
        chk("mid_rst_ip_dst", 64'(ip_dst), 64'd0);
        hold_reset();
        pkt_cnt[0] = 1; pkt_len[0][0] = 3;
        pkt_cnt[1] = 1; pkt_len[1][0] = 3;
        begin_test(4'b1111);
        n = expq.size();
        run(n);
        finish_checks("post_rst");

        // Random traffic with 50% framer backpressure
        for (int it = 0; it < 6; it++) begin
            hold_reset();
            en = NP'($urandom_range(15));
            if (en == '0) en = 4'b0001;
            for (int p = 0; p < NP; p++) begin
                pkt_cnt[p] = $urandom_range(4);
                for (int k = 0; k < pkt_cnt[p]; k++)
                    pkt_len[p][k] = $urandom_range(12, 1);
            end
            ready_pct = 50;
            begin_test(en);
            n = expq.size();
            run(n);
            finish_checks("rand");
            chk("rand_beats", 64'(mon_beats), 64'(n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
